// File: rtl/pkt_parser.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_parser
//  Description : Receives 8-byte packets one byte per cycle. It checks the
//                XOR checksum and the packet type. Fields of good packets
//                are held on the outputs. Bad, aborted or timed-out packets
//                raise a one-cycle pkt_err pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module pkt_parser #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  output logic [2:0]  fPktType,
  output logic [15:0] sourceID,
  output logic [15:0] destinationID,
  output logic [15:0] payload,
  output logic        newpkt,
  output logic        pkt_err,
  output logic        busy
);

  // Gap counter only has to count up to TIMEOUT-1. The TIMEOUT-th idle
  // cycle aborts the packet instead of incrementing the counter again.
  localparam int            GW       = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RECV = 1'b1;

  logic [0:0]    state, state_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    xor_q, xor_n;
  logic [GW-1:0] gap, gap_n;
  logic [2:0]    b_type, b_type_n;
  logic [15:0]   b_src, b_src_n;
  logic [15:0]   b_dst, b_dst_n;
  logic [15:0]   b_pay, b_pay_n;
  logic          good_evt, err_evt;

  // State register
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state and datapath decode; also flags packet completion/drop events
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    xor_n    = xor_q;
    gap_n    = gap;
    b_type_n = b_type;
    b_src_n  = b_src;
    b_dst_n  = b_dst;
    b_pay_n  = b_pay;
    good_evt = 1'b0;
    err_evt  = 1'b0;
    case (state)
      S_IDLE: begin
        // Bytes without sop in IDLE are dropped silently
        if (in_valid && in_sop) begin
          state_n  = S_RECV;
          idx_n    = 3'd1;
          xor_n    = in_data;
          gap_n    = '0;
          b_type_n = in_data[7:5];
        end
      end
      S_RECV: begin
        if (in_valid) begin
          gap_n = '0;
          if (in_sop) begin
            // Abort the current packet; this byte starts the next one
            err_evt  = 1'b1;
            idx_n    = 3'd1;
            xor_n    = in_data;
            b_type_n = in_data[7:5];
          end else if (idx == 3'd7) begin
            state_n = S_IDLE;
            idx_n   = 3'd0;
            if (in_data == xor_q && b_type != 3'b111) good_evt = 1'b1;
            else                                      err_evt  = 1'b1;
          end else begin
            xor_n = xor_q ^ in_data;
            idx_n = idx + 3'd1;
            case (idx)
              3'd1:    b_src_n[15:8] = in_data;
              3'd2:    b_src_n[7:0]  = in_data;
              3'd3:    b_dst_n[15:8] = in_data;
              3'd4:    b_dst_n[7:0]  = in_data;
              3'd5:    b_pay_n[15:8] = in_data;
              3'd6:    b_pay_n[7:0]  = in_data;
              default: ;
            endcase
          end
        end else if (gap == GAP_LAST) begin
          state_n = S_IDLE;
          idx_n   = 3'd0;
          gap_n   = '0;
          err_evt = 1'b1;
        end else begin
          gap_n = gap + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == S_RECV);
  end

  // Datapath registers: byte index, running XOR, gap counter, capture buffer
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      idx    <= 3'd0;
      xor_q  <= 8'd0;
      gap    <= '0;
      b_type <= 3'd0;
      b_src  <= 16'd0;
      b_dst  <= 16'd0;
      b_pay  <= 16'd0;
    end else begin
      idx    <= idx_n;
      xor_q  <= xor_n;
      gap    <= gap_n;
      b_type <= b_type_n;
      b_src  <= b_src_n;
      b_dst  <= b_dst_n;
      b_pay  <= b_pay_n;
    end
  end

  // Result registers. Fields move only on a good packet; pulses last one cycle
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      fPktType      <= 3'd0;
      sourceID      <= 16'd0;
      destinationID <= 16'd0;
      payload       <= 16'd0;
      newpkt        <= 1'b0;
      pkt_err       <= 1'b0;
    end else begin
      newpkt  <= good_evt;
      pkt_err <= err_evt;
      if (good_evt) begin
        fPktType      <= b_type;
        sourceID      <= b_src;
        destinationID <= b_dst;
        payload       <= b_pay;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pkt_parser
//  Description : Scoreboard bench for pkt_parser. Expected pulses are queued
//                when packets are driven and popped when the DUT pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pkt_parser;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sop;
  logic [2:0]  fPktType;
  logic [15:0] sourceID;
  logic [15:0] destinationID;
  logic [15:0] payload;
  logic        newpkt;
  logic        pkt_err;
  logic        busy;

  pkt_parser #(.TIMEOUT(16)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_sop        (in_sop),
    .fPktType      (fPktType),
    .sourceID      (sourceID),
    .destinationID (destinationID),
    .payload       (payload),
    .newpkt        (newpkt),
    .pkt_err       (pkt_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [2:0]  t;
    logic [15:0] s;
    logic [15:0] d;
    logic [15:0] p;
  } exp_t;

  localparam logic [63:0] P_GOOD = 64'hA000_0500_0312_3480;
  localparam logic [63:0] P_BADC = 64'hA000_0500_0312_3481;
  localparam logic [63:0] P_T7   = 64'hE000_0100_0200_00E3;
  localparam logic [63:0] P_TWO  = 64'h4012_3456_789A_BC6E;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  int          good_cycles[$];
  logic [2:0]  m_t = '0;
  logic [15:0] m_s = '0, m_d = '0, m_p = '0;

  always @(posedge clk) cycle <= cycle + 1;

  // Pulse monitor: every newpkt/pkt_err must match the head of the scoreboard
  always @(negedge clk) begin
    if (newpkt && pkt_err) begin
      checks++; errors++;
      $display("FAIL both_pulses: newpkt=1 pkt_err=1, required at most one");
    end else if (newpkt || pkt_err) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: newpkt=%0b pkt_err=%0b, required none", newpkt, pkt_err);
      end else begin
        mon_e = sb.pop_front();
        if (pkt_err !== mon_e.err ||
            {fPktType, sourceID, destinationID, payload} !== {mon_e.t, mon_e.s, mon_e.d, mon_e.p}) begin
          errors++;
          $display("FAIL pulse_fields: err=%0b t=%h s=%h d=%h p=%h, required err=%0b t=%h s=%h d=%h p=%h",
                   pkt_err, fPktType, sourceID, destinationID, payload,
                   mon_e.err, mon_e.t, mon_e.s, mon_e.d, mon_e.p);
        end
        if (newpkt) good_cycles.push_back(cycle);
      end
    end
  end

  function automatic logic [7:0] byte_of(input logic [63:0] p, input int i);
    return p[63-8*i -: 8];
  endfunction

  // Reference model: decide good/bad from the raw bytes and queue the outcome
  task automatic push_pkt(input logic [63:0] p);
    logic [7:0] x;
    exp_t       e;
    x = 8'h00;
    for (int i = 0; i < 7; i++) x = x ^ byte_of(p, i);
    if (byte_of(p, 7) == x && p[63:61] != 3'b111) begin
      m_t = p[63:61]; m_s = p[55:40]; m_d = p[39:24]; m_p = p[23:8];
      e.err = 1'b0;
    end else begin
      e.err = 1'b1;
    end
    e.t = m_t; e.s = m_s; e.d = m_d; e.p = m_p;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.err = 1'b1; e.t = m_t; e.s = m_s; e.d = m_d; e.p = m_p;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    in_valid = v; in_sop = s; in_data = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [63:0] p, input int from, input int to, input bit sop_first);
    for (int i = from; i <= to; i++) drive(1'b1, (i == from) && sop_first, byte_of(p, i));
  endtask

  task automatic check_drained(input string name);
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulses missing, required 0", name, sb.size());
    end
  endtask

  task automatic check_busy(input string name, input logic exp);
    checks++;
    if (busy !== exp) begin
      errors++;
      $display("FAIL %s: busy=%0b, required %0b", name, busy, exp);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({fPktType, sourceID, destinationID, payload, newpkt, pkt_err, busy} !== '0) begin
      errors++;
      $display("FAIL %s: t=%h s=%h d=%h p=%h newpkt=%0b pkt_err=%0b busy=%0b, required all 0",
               name, fPktType, sourceID, destinationID, payload, newpkt, pkt_err, busy);
    end
  endtask

  task automatic check_fields(input string name);
    checks++;
    if ({fPktType, sourceID, destinationID, payload} !== {m_t, m_s, m_d, m_p}) begin
      errors++;
      $display("FAIL %s: t=%h s=%h d=%h p=%h, required t=%h s=%h d=%h p=%h",
               name, fPktType, sourceID, destinationID, payload, m_t, m_s, m_d, m_p);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    nrst = 1'b0;
    idle(1);
    // First byte after reset without sop must not start a packet
    send(P_GOOD, 0, 7, 1'b0);
    check_busy("no_sop_after_reset", 1'b0);
    check_drained("no_sop_after_reset_pulses");
  endtask

  task automatic test_good();
    push_pkt(P_GOOD);
    send(P_GOOD, 0, 6, 1'b1);
    check_busy("good_busy_mid", 1'b1);
    send(P_GOOD, 7, 7, 1'b0);
    check_busy("good_busy_end", 1'b0);
    check_drained("good_pulse");
    idle(20);
    check_fields("good_fields_hold");
  endtask

  task automatic test_bad_checksum();
    push_pkt(P_BADC);
    send(P_BADC, 0, 7, 1'b1);
    check_drained("bad_checksum_pulse");
    check_fields("bad_checksum_fields_kept");
  endtask

  task automatic test_type7();
    push_pkt(P_T7);
    send(P_T7, 0, 7, 1'b1);
    check_drained("type7_pulse");
  endtask

  task automatic test_timeout();
    push_pkt(P_TWO);
    send(P_TWO, 0, 3, 1'b1);
    idle(15);
    check_busy("gap15_busy", 1'b1);
    send(P_TWO, 4, 7, 1'b0);
    check_drained("gap15_pulse");
    check_fields("gap15_fields");
    push_err();
    send(P_GOOD, 0, 3, 1'b1);
    idle(15);
    check_busy("gap16_busy_before", 1'b1);
    idle(1);
    check_busy("gap16_busy_after", 1'b0);
    check_drained("gap16_pulse");
    send(P_GOOD, 4, 7, 1'b0);
    check_busy("gap16_tail_ignored", 1'b0);
    check_drained("gap16_tail_pulses");
  endtask

  task automatic test_sop_abort();
    send(P_GOOD, 0, 3, 1'b1);
    push_err();
    push_pkt(P_TWO);
    send(P_TWO, 0, 7, 1'b1);
    check_drained("sop_abort_pulses");
    check_fields("sop_abort_fields");
  endtask

  task automatic test_back_to_back();
    push_pkt(P_GOOD);
    push_pkt(P_TWO);
    good_cycles.delete();
    send(P_GOOD, 0, 7, 1'b1);
    send(P_TWO, 0, 7, 1'b1);
    check_drained("b2b_pulses");
    checks++;
    if (good_cycles.size() != 2 || (good_cycles[1] - good_cycles[0]) != 8) begin
      errors++;
      $display("FAIL b2b_spacing: %0d pulses spacing %0d, required 2 pulses spacing 8",
               good_cycles.size(), good_cycles.size() == 2 ? good_cycles[1] - good_cycles[0] : -1);
    end
    // Third packet interrupted by reset while B3 is on the bus
    send(P_GOOD, 0, 2, 1'b1);
    check_busy("third_busy", 1'b1);
    in_valid = 1'b1; in_sop = 1'b0; in_data = byte_of(P_GOOD, 3);
    #2 nrst = 1'b1;
    #1;
    check_zero("mid_packet_reset");
    m_t = '0; m_s = '0; m_d = '0; m_p = '0;
    @(posedge clk); #1;
    nrst = 1'b0;
    idle(1);
    check_drained("mid_packet_reset_no_err");
    check_busy("after_reset_busy", 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good();
    test_bad_checksum();
    test_type7();
    test_timeout();
    test_sop_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
